x_play_seq: RTL and testbench

Playback sequencer between the shared memory port and the DAC thermometer encoder. Once started, it fetches a programmed run of samples from memory and presents one clamped binary code per sample period to the encoder. It requests the memory port through a req/gnt handshake; the host control path has priority at the arbiter. It supports one-shot and looped playback and flags underruns.

---
 rtl/x_play_pkg.sv | 9 +
 rtl/x_play_tick.sv | 26 ++
 rtl/x_play_seq.sv | 152 +++++++++++++++
 tb/tb_x_play_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_play_pkg.sv
// x_play_pkg: shared types, default constants and sample clamp for the playback sequencer
package x_play_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam int CODE_MAX_D  = 64;
  localparam int IDLE_CODE_D = 32;
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] max);
    return v > max ? max : v;
  endfunction
endpackage

// File: rtl/x_play_tick.sv
// x_play_tick: loadable period down-counter; ticks when it reaches zero and reloads the period
module x_play_tick (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [15:0] i_div,
  output logic        o_tick
);
  logic [15:0] period;
  logic [15:0] cnt;
  assign o_tick = i_en && cnt == 16'd0;
  // Load period on start, count down while enabled, reload on each tick
  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_clr) begin
      period <= '0;
      cnt    <= '0;
    end else if (i_load) begin
      period <= i_div;
      cnt    <= i_div;
    end else if (i_en) begin
      cnt <= o_tick ? period : cnt - 16'd1;
    end
  end
endmodule

// File: rtl/x_play_seq.sv
// x_play_seq: memory-fed playback sequencer for the DAC encoder; define X_PLAY_SEQ_URCNT_EN to add o_urcnt
module x_play_seq
  import x_play_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BIN_W     = 7,
  parameter int CODE_MAX  = CODE_MAX_D,
  parameter int RD_LAT    = 1,
  parameter int IDLE_CODE = IDLE_CODE_D
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  input  logic [15:0]       i_div,
  input  logic              i_loop,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [BIN_W-1:0]  o_bin,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_underrun
`ifdef X_PLAY_SEQ_URCNT_EN
  ,
  output logic [15:0]       o_urcnt
`endif
);
  localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic              loop;
  logic [ADDR_W:0]   fetched;
  logic [ADDR_W:0]   played;
  logic [ADDR_W:0]   total;
  logic [BIN_W-1:0]  buf_q;
  logic              full;
  logic [LW-1:0]     wait_cnt;
  logic              tick;
  logic              start_ok;
  logic              last;
  assign o_busy   = state != IDLE;
  assign start_ok = state == IDLE && i_start && !i_stop;
  assign total    = (ADDR_W+1)'(len + 1);
  assign last     = played == total;
  x_play_tick u_tick (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_clr  (o_busy && (i_stop || (last && !loop))),
    .i_load (start_ok),
    .i_en   (o_busy),
    .i_div  (i_div),
    .o_tick (tick)
  );
  // Sequencer: fetch one sample ahead, play it on each tick, loop or finish after the last
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state      <= IDLE;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      base       <= '0;
      len        <= '0;
      loop       <= 1'b0;
      fetched    <= '0;
      played     <= '0;
      buf_q      <= '0;
      full       <= 1'b0;
      wait_cnt   <= '0;
      o_bin      <= BIN_W'(IDLE_CODE);
      o_done     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_underrun <= 1'b0;
      if (state == IDLE) begin
        if (start_ok) begin
          base       <= i_base;
          len        <= i_len;
          loop       <= i_loop;
          o_mem_addr <= i_base;
          fetched    <= '0;
          played     <= '0;
          full       <= 1'b0;
          state      <= REQ;
          o_mem_req  <= 1'b1;
        end
      end else if (i_stop) begin
        state     <= IDLE;
        o_mem_req <= 1'b0;
        full      <= 1'b0;
        o_bin     <= BIN_W'(IDLE_CODE);
      end else begin
        if (tick) begin
          if (full) begin
            o_bin  <= buf_q;
            full   <= 1'b0;
            played <= (ADDR_W+1)'(played + 1);
          end else begin
            o_underrun <= 1'b1;
          end
        end
        if (last) begin
          if (loop) begin
            o_mem_addr <= base;
            fetched    <= '0;
            played     <= '0;
            state      <= REQ;
            o_mem_req  <= 1'b1;
          end else begin
            o_done    <= 1'b1;
            state     <= IDLE;
            o_mem_req <= 1'b0;
          end
        end else begin
          case (state)
            REQ: if (i_mem_gnt) begin
              o_mem_addr <= ADDR_W'(o_mem_addr + 1);
              fetched    <= (ADDR_W+1)'(fetched + 1);
              o_mem_req  <= 1'b0;
              wait_cnt   <= LW'(RD_LAT - 1);
              state      <= WAIT;
            end
            WAIT: if (wait_cnt == '0) begin
              buf_q <= BIN_W'(clamp(32'(i_mem_rdata), CODE_MAX));
              full  <= 1'b1;
              state <= HOLD;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
            HOLD: if (fetched < total && !full) begin
              state     <= REQ;
              o_mem_req <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end
`ifdef X_PLAY_SEQ_URCNT_EN
  // Saturating underrun tally, cleared by reset and by an accepted start
  always_ff @(posedge i_clk) begin
    if (!i_nrst || start_ok) o_urcnt <= '0;
    else if (o_busy && !i_stop && tick && !full && o_urcnt != 16'hFFFF) o_urcnt <= o_urcnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_x_play_seq.sv
// tb_x_play_seq: vector table, corner sequences and randomized playback against a tick-level model
module tb_x_play_seq;
  typedef struct packed {
    logic [7:0]      b;
    logic [7:0]      l;
    logic [15:0]     dv;
    logic [3:0][7:0] d;
    logic [3:0][6:0] e;
  } vec_t;

  logic        clk;
  logic        nrst;
  logic        start;
  logic        stop;
  logic [7:0]  base;
  logic [7:0]  len;
  logic [15:0] div;
  logic        loop;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        gnt;
  logic [7:0]  rdata;
  logic [6:0]  bin;
  logic        busy;
  logic        done;
  logic        underrun;
`ifdef X_PLAY_SEQ_URCNT_EN
  logic [15:0] urcnt;
`endif

  logic [7:0] mem [256];
  logic [7:0] acc_log [$];
  logic [6:0] exp_q [$];
  int n_pass;
  int n_tot;
  int ur_seen;
  int done_seen;
  int cur_bin;
  vec_t vt [4];

  x_play_seq dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_start     (start),
    .i_stop      (stop),
    .i_base      (base),
    .i_len       (len),
    .i_div       (div),
    .i_loop      (loop),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_gnt   (gnt),
    .i_mem_rdata (rdata),
    .o_bin       (bin),
    .o_busy      (busy),
    .o_done      (done),
    .o_underrun  (underrun)
`ifdef X_PLAY_SEQ_URCNT_EN
    ,
    .o_urcnt     (urcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, garbage on the bus otherwise; logs accepted addresses
  always @(posedge clk) begin
    if (mem_req && gnt) begin
      rdata <= mem[mem_addr];
      acc_log.push_back(mem_addr);
    end else begin
      rdata <= 8'($urandom);
    end
  end

  always @(negedge clk) begin
    if (underrun) ur_seen++;
    if (done) done_seen++;
  end

  function automatic int mc(input int v);
    return v > 64 ? 64 : v;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic play(input logic [7:0] b, input logic [7:0] l, input logic [15:0] dv, input logic lp, input int nt);
    int a0, u0, d0;
    a0 = acc_log.size();
    u0 = ur_seen;
    d0 = done_seen;
    base = b; len = l; div = dv; loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < nt; i++) begin
      repeat (dv) @(negedge clk);
      chk("bin_before_tick", bin, cur_bin);
      @(negedge clk);
      chk("bin_at_tick", bin, exp_q[i]);
      cur_bin = exp_q[i];
    end
    if (!lp) begin
      chk("done_not_early", done, 0);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("idle_after_done", busy, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("bin_holds_last", bin, cur_bin);
      chk("done_count", done_seen - d0, 1);
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_req", mem_req, 0);
      chk("stop_bin", bin, 32);
      chk("loop_no_done", done_seen - d0, 0);
      cur_bin = 32;
    end
    chk("no_underrun", ur_seen - u0, 0);
    chk("fetch_count", acc_log.size() - a0, nt);
    for (int i = 0; i < nt && a0 + i < acc_log.size(); i++)
      chk("fetch_addr", acc_log[a0 + i], (int'(b) + i % (int'(l) + 1)) % 256);
  endtask

  initial begin
    n_pass = 0; n_tot = 0; ur_seen = 0; done_seen = 0; cur_bin = 32;
    nrst = 1'b0; start = 1'b0; stop = 1'b0; gnt = 1'b1;
    base = '0; len = '0; div = '0; loop = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_bin", bin, 32);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
`ifdef X_PLAY_SEQ_URCNT_EN
    chk("rst_urcnt", urcnt, 0);
`endif
    nrst = 1'b1;
    @(negedge clk);

    // base, len, div, samples (d[0] rightmost), expected codes
    vt[0] = {8'h10, 8'd3, 16'd9, {8'd0, 8'd64, 8'd20, 8'd5},  {7'd0, 7'd64, 7'd20, 7'd5}};
    vt[1] = {8'h40, 8'd2, 16'd5, {8'd0, 8'd63, 8'd65, 8'hC8}, {7'd0, 7'd63, 7'd64, 7'd64}};
    vt[2] = {8'hFE, 8'd3, 16'd3, {8'd4, 8'd3, 8'd2, 8'd1},    {7'd4, 7'd3, 7'd2, 7'd1}};
    vt[3] = {8'h80, 8'd0, 16'd2, {8'd0, 8'd0, 8'd0, 8'hFF},   {7'd0, 7'd0, 7'd0, 7'd64}};
    for (int v = 0; v < 4; v++) begin
      exp_q.delete();
      for (int i = 0; i <= int'(vt[v].l); i++) begin
        mem[8'(vt[v].b + 8'(i))] = vt[v].d[i];
        exp_q.push_back(vt[v].e[i]);
      end
      play(vt[v].b, vt[v].l, vt[v].dv, 1'b0, int'(vt[v].l) + 1);
    end

    // Looped two-sample playback, no gap between passes
    mem[8'h20] = 8'd7;
    mem[8'h21] = 8'd9;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(i % 2 == 0 ? 7'd7 : 7'd9);
    play(8'h20, 8'd1, 16'd4, 1'b1, 6);

    // Grant withheld for 12 cycles: underruns on ticks 1 and 2, late sample on tick 3
    mem[8'h30] = 8'd11;
    mem[8'h31] = 8'd22;
    gnt = 1'b0; base = 8'h30; len = 8'd1; div = 16'd4; loop = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      chk("ur_pulse", underrun, (k == 5 || k == 10) ? 1 : 0);
      chk("ur_bin", bin, k < 15 ? 32 : k < 20 ? 11 : 22);
      chk("ur_done", done, k == 21 ? 1 : 0);
      chk("ur_busy", busy, k < 21 ? 1 : 0);
      if (k == 6) begin
        chk("req_held", mem_req, 1);
        chk("addr_held", mem_addr, 8'h30);
      end
      if (k == 12) gnt = 1'b1;
    end
`ifdef X_PLAY_SEQ_URCNT_EN
    chk("urcnt", urcnt, 2);
`endif
    cur_bin = 22;

    // Stop while the read is in flight
    mem[8'h50] = 8'd44;
    base = 8'h50; len = 8'd0; div = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wait_req", mem_req, 1);
    chk("wait_addr", mem_addr, 8'h50);
    @(negedge clk);
    chk("wait_req_drop", mem_req, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stopw_busy", busy, 0);
    chk("stopw_req", mem_req, 0);
    chk("stopw_bin", bin, 32);
    repeat (12) @(negedge clk);
    chk("stopw_bin_late", bin, 32);
    chk("stopw_idle", busy, 0);
    cur_bin = 32;

    // Start and stop together in IDLE: stays idle
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_req", mem_req, 0);
    repeat (3) @(negedge clk);
    chk("ss_busy_later", busy, 0);

    // Reset mid-operation
    begin
      int d0;
      d0 = done_seen;
      base = 8'h60; len = 8'd3; div = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      chk("mrst_busy", busy, 0);
      chk("mrst_bin", bin, 32);
      chk("mrst_req", mem_req, 0);
      chk("mrst_done", done, 0);
`ifdef X_PLAY_SEQ_URCNT_EN
      chk("mrst_urcnt", urcnt, 0);
`endif
      repeat (20) @(negedge clk);
      chk("mrst_no_done", done_seen - d0, 0);
      chk("mrst_idle", busy, 0);
      cur_bin = 32;
    end

    // Randomized playback against the tick-level model
    for (int r = 0; r < 16; r++) begin
      logic [7:0] b, l;
      logic [15:0] dv;
      logic lp;
      int nt;
      b  = 8'($urandom);
      l  = 8'($urandom_range(0, 7));
      dv = 16'($urandom_range(3, 10));
      lp = 1'($urandom_range(0, 1));
      nt = lp ? 2 * (int'(l) + 1) + 1 : int'(l) + 1;
      for (int i = 0; i <= int'(l); i++) mem[8'(b + 8'(i))] = 8'($urandom_range(0, 100));
      exp_q.delete();
      for (int i = 0; i < nt; i++) exp_q.push_back(7'(mc(int'(mem[8'(b + 8'(i % (int'(l) + 1)))]))));
      play(b, l, dv, lp, nt);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
